harp_tone_gen: RTL and testbench
================================

Name: harp_tone_gen

Overview:
- Downstream of the octave/semitone modulation stage: consumes the eight 20-bit half-duty-cycle counts (C..high C) plus the eight laser-beam sensor lines.
- For each broken beam it runs a square-wave oscillator at the selected pitch and mixes all active notes into one signed sample.
- Samples go to the audio codec interface over a valid/ready handshake. A per-note activity vector drives LEDs.
- Clock is the 50 MHz system clock; half-duty-cycle counts are in system-clock cycles.

Parameters:
- NUM_NOTES, 8, number of harp strings/oscillators; fixed by the package, not overridden.
- HDC_W, 20, width of each half-duty-cycle count.
- SAMPLE_W, 24, width of the signed output sample.
- AMPLITUDE, 1000000, per-note square-wave magnitude; NUM_NOTES*AMPLITUDE must be at most 2^(SAMPLE_W-1)-1.
- DEBOUNCE_CYC, 500000, consecutive stable cycles (10 ms) required to change a note gate.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- sensor  in  8  raw beam-broken inputs, bit0=C ... bit7=high C; asynchronous to clk
- hdc_C, hdc_D, hdc_E, hdc_F, hdc_G, hdc_A, hdc_B, hdc_C_h  in  20 each  half-duty-cycle counts from the modulation stage
- out_ready  in  1  codec accepts a sample this cycle
- out_valid  out  1  sample available
- out_sample  out  24  signed two's-complement mixed sample
- note_active  out  8  debounced gate per note

Behaviour:
- Reset: all sync flops, debounce counters, oscillator counters and phases, mix register and out_sample go to 0. out_valid=0 and note_active=0. Reset mid-note silences immediately; the first post-reset sample is 0.
- Input sync: each sensor bit passes through a 2-flop synchronizer, giving sync[i] with 2 cycles of latency.
- Debounce (DEBOUNCE_EN):
  - While sync[i] != gate[i], db_cnt[i] increments. When it reaches DEBOUNCE_CYC-1, gate[i] takes sync[i] and db_cnt[i] clears.
  - Any cycle with sync[i]==gate[i] clears db_cnt[i].
  - The counter saturates and never wraps.
- note_active = gate; it is a register output.
- Oscillator i:
  - gate[i]=0 or hdc_i==0: cnt=0, phase=0.
  - Otherwise, if cnt >= hdc_i-1: cnt=0 and phase toggles; else cnt increments.
  - The >= compare means a mid-note hdc decrease (octave or semitone change) wraps on the next cycle, and a new pitch takes effect without restarting the note.
  - The first edge after the gate rises lands hdc_i cycles later, i.e. period = 2*hdc_i cycles.
- Mixer:
  - Contribution_i = 0 if gate[i]=0; +AMPLITUDE if phase=1; -AMPLITUDE if phase=0.
  - Signed sum over 8 notes is sign-extended to SAMPLE_W and registered each cycle into mix_r. Latency is 1 cycle from phase to mix_r.
  - No saturation logic is needed; the parameter constraint guarantees no overflow.
- Output handshake:
  - Load when out_valid=0 or (out_valid & out_ready): out_sample <= mix_r and out_valid <= 1.
  - While out_valid & !out_ready, out_sample holds stable.
  - After reset, out_valid asserts on the 2nd cycle. Because out_valid stays 1 after that, each accept loads the next fresh mix_r.
- Simultaneous events: gate change and wrap in the same cycle follow the gate-off rule. Accept and load in the same cycle is the normal throughput of one sample per cycle.

Optional Feature:
- Macro: HARP_DEBOUNCE_EN.
- Defined: debounce as above.
- Undefined: gate[i] = sync[i] registered once (1 cycle), with no db_cnt logic. Used for fast simulation and for clean optical sensors.

Decomposition:
- Shared package harp_pkg holds:
  - NUM_NOTES=8, HDC_W=20, SAMPLE_W=24
  - a typedef for the hdc count
  - a typedef for the signed sample
  - note index constants NOTE_C..NOTE_C_H (0..7)
- Sub-module note_osc (sync, debounce, counter and phase for one note; outputs gate and phase) is instantiated 8 times. The mixer and handshake live in harp_tone_gen.

Test Plan:
- Reset release, no sensors, out_ready=1 -> out_valid=1 by cycle 2; out_sample=0 and note_active=0 continuously.
- Macro undefined, hdc_C=4, sensor[0]=1 -> note_active[0] rises 3 cycles later; out_sample alternates -1000000/+1000000 with period 8 cycles.
- Macro defined, DEBOUNCE_CYC=4, sensor[0] glitch high for 3 cycles -> note_active stays 0. Held high for 6 cycles -> note_active[0]=1 after 2+4 cycles.
- All 8 sensors active with equal hdc=10 -> out_sample toggles between +8000000 and -8000000 with no overflow.
- Note C active with hdc_C=100, cnt≈60; switch hdc_C to 20 -> wrap on the next cycle, then period 40 cycles.
- out_ready=0 for 50 cycles while notes toggle -> out_sample frozen at the first loaded value. out_ready=1 -> the value updates the next cycle. Reset asserted mid-note -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/harp_pkg.sv
// Shared constants and types for the harp tone generator and its per-note oscillators.
package harp_pkg;
    localparam int NUM_NOTES    = 8;
    localparam int HDC_W        = 20;
    localparam int SAMPLE_W     = 24;
    localparam int AMPLITUDE    = 1000000;
    localparam int DEBOUNCE_CYC = 500000;

    typedef logic [HDC_W-1:0]           hdc_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam int NOTE_C   = 0;
    localparam int NOTE_D   = 1;
    localparam int NOTE_E   = 2;
    localparam int NOTE_F   = 3;
    localparam int NOTE_G   = 4;
    localparam int NOTE_A   = 5;
    localparam int NOTE_B   = 6;
    localparam int NOTE_C_H = 7;
endpackage

// File: rtl/note_osc.sv
// One harp string: beam synchronizer, gate qualification and square-wave phase counter.
// Build with HARP_DEBOUNCE_EN to filter the gate through a stability counter.
module note_osc
   import harp_pkg::*;
   #(parameter int DB_CYC = DEBOUNCE_CYC)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             sensor,
   input  logic [HDC_W-1:0] hdc,
   output logic             gate,
   output logic             phase
);
   logic             sync_meta;
   logic             sync;
   logic [HDC_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= sensor;
         sync      <= sync_meta;
      end
   end

`ifdef HARP_DEBOUNCE_EN
   localparam int              DB_W    = $clog2(DB_CYC + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);
   logic [DB_W-1:0] db_cnt;

   // Gate only moves after DB_CYC consecutive cycles of disagreement; >= keeps it from wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         gate   <= 1'b0;
         db_cnt <= '0;
      end else if (sync == gate) begin
         db_cnt <= '0;
      end else if (db_cnt >= DB_LAST) begin
         gate   <= sync;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) gate <= 1'b0;
      else       gate <= sync;
   end
`endif

   // >= lets a mid-note pitch drop wrap immediately instead of running past the new limit.
   always_ff @(posedge clk) begin
      if (reset || !gate || hdc == '0) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt >= hdc - 1'b1) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/harp_tone_gen.sv
// Eight-string laser harp tone generator: per-note oscillators, mixer and codec handshake.
// Optional HARP_DEBOUNCE_EN enables sensor debouncing inside each oscillator.
module harp_tone_gen
   import harp_pkg::*;
   #(parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYC)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          sensor,
   input  logic [HDC_W-1:0]    hdc_C,
   input  logic [HDC_W-1:0]    hdc_D,
   input  logic [HDC_W-1:0]    hdc_E,
   input  logic [HDC_W-1:0]    hdc_F,
   input  logic [HDC_W-1:0]    hdc_G,
   input  logic [HDC_W-1:0]    hdc_A,
   input  logic [HDC_W-1:0]    hdc_B,
   input  logic [HDC_W-1:0]    hdc_C_h,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [SAMPLE_W-1:0] out_sample,
   output logic [7:0]          note_active
);
   localparam sample_t AMP = sample_t'(AMPLITUDE);

   logic [HDC_W-1:0]     hdc [NUM_NOTES];
   logic [NUM_NOTES-1:0] gate;
   logic [NUM_NOTES-1:0] phase;
   sample_t              mix_next;
   sample_t              mix_r;

   assign hdc[NOTE_C]   = hdc_C;
   assign hdc[NOTE_D]   = hdc_D;
   assign hdc[NOTE_E]   = hdc_E;
   assign hdc[NOTE_F]   = hdc_F;
   assign hdc[NOTE_G]   = hdc_G;
   assign hdc[NOTE_A]   = hdc_A;
   assign hdc[NOTE_B]   = hdc_B;
   assign hdc[NOTE_C_H] = hdc_C_h;

   for (genvar i = 0; i < NUM_NOTES; i++) begin : g_note
      note_osc #(.DB_CYC(DEBOUNCE_CYCLES)) u_osc (
         .clk    (clk),
         .reset  (reset),
         .sensor (sensor[i]),
         .hdc    (hdc[i]),
         .gate   (gate[i]),
         .phase  (phase[i])
      );
   end

   // NUM_NOTES*AMPLITUDE fits in SAMPLE_W signed, so the sum cannot overflow.
   always_comb begin
      mix_next = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         if (gate[i]) mix_next = phase[i] ? mix_next + AMP : mix_next - AMP;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mix_r      <= '0;
         out_valid  <= 1'b0;
         out_sample <= '0;
      end else begin
         mix_r <= mix_next;
         if (!out_valid || out_ready) begin
            out_sample <= mix_r;
            out_valid  <= 1'b1;
         end
      end
   end

   assign note_active = gate;
endmodule

// File: tb/tb_harp_tone_gen.sv
// Self-checking bench for harp_tone_gen: vector table, hand sequences and a randomized model run.
module tb_harp_tone_gen;
   localparam int A = 1000000;
   localparam int DB_PARAM = 4;
`ifdef HARP_DEBOUNCE_EN
   localparam int DBM = 4;
`else
   localparam int DBM = 1;
`endif
   // Cycle index (after reset release) at which a sensor raised right after release gates on.
   localparam int R = 2 + DBM;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  sensor = '0;
   logic [19:0] hdc_v [8];
   logic        out_ready = 1'b1;
   logic        out_valid;
   logic [23:0] out_sample;
   logic [7:0]  note_active;

   int n = 0;
   int checks = 0;
   int passes = 0;

   logic [7:0] sl[$];
   logic       rl[$];
   int         csum[$];

   typedef struct {
      logic [7:0] mask;
      int         hdc;
      int         k;
      int         exp_s;
   } vec_t;
   vec_t vt[12];

   harp_tone_gen #(.DEBOUNCE_CYCLES(DB_PARAM)) dut (
      .clk         (clk),
      .reset       (reset),
      .sensor      (sensor),
      .hdc_C       (hdc_v[0]),
      .hdc_D       (hdc_v[1]),
      .hdc_E       (hdc_v[2]),
      .hdc_F       (hdc_v[3]),
      .hdc_G       (hdc_v[4]),
      .hdc_A       (hdc_v[5]),
      .hdc_B       (hdc_v[6]),
      .hdc_C_h     (hdc_v[7]),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_sample  (out_sample),
      .note_active (note_active)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic run_to(input int t);
      while (n < t) step();
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, n, act, exp);
   endtask

   function automatic int smp();
      return int'($signed(out_sample));
   endfunction

   task automatic set_hdc_all(input int h);
      for (int i = 0; i < 8; i++) hdc_v[i] = 20'(h);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      sensor = '0;
      out_ready = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      n = 0;
   endtask

   function automatic logic sync_of(input int m, input int i);
      logic [7:0] v;
      if (m < 2) return 1'b0;
      v = sl[m-2];
      return v[i];
   endfunction

   // Model: gate follows a DBM-long window of agreeing synced values; phase derives from time since rise.
   task automatic run_random(input int cycles);
      int rise[8];
      logic [7:0] gm;
      logic vm, v, ok;
      int om, mixm, c, h;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         hdc_v[i] = 20'($urandom_range(0, 12));
         rise[i] = 0;
      end
      sl.delete(); rl.delete(); csum.delete();
      gm = '0; vm = 1'b0; om = 0; mixm = 0;
      sensor = 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      sl.push_back(sensor); rl.push_back(out_ready); csum.push_back(0);
      for (int t = 1; t <= cycles; t++) begin
         step();
         if (!vm || rl[t-1]) begin
            om = mixm;
            vm = 1'b1;
         end
         mixm = csum[t-1];
         for (int i = 0; i < 8; i++) begin
            v = sync_of(t - 1, i);
            ok = 1'b1;
            for (int j = 1; j <= DBM; j++) if (sync_of(t - j, i) != v) ok = 1'b0;
            if (ok && v != gm[i]) begin
               gm[i] = v;
               if (v) rise[i] = t;
            end
         end
         c = 0;
         for (int i = 0; i < 8; i++) begin
            h = int'(hdc_v[i]);
            if (gm[i]) c += (h != 0 && ((t - rise[i]) / h) % 2 == 1) ? A : -A;
         end
         csum.push_back(c);
         chk("rnd_valid", int'(out_valid), int'(vm));
         chk("rnd_sample", smp(), om);
         chk("rnd_active", int'(note_active), int'(gm));
         for (int i = 0; i < 8; i++) if ($urandom_range(0, 9) == 0) sensor[i] = ~sensor[i];
         out_ready = ($urandom_range(0, 3) != 0);
         sl.push_back(sensor); rl.push_back(out_ready);
      end
   endtask

   initial begin
      set_hdc_all(0);

      // Startup: valid rises one cycle after release, sample and gates stay zero.
      apply_reset();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_sample", smp(), 0);
      chk("rst_active", int'(note_active), 0);
      step();
      chk("start_valid", int'(out_valid), 1);
      repeat (8) begin
         step();
         chk("idle_sample", smp(), 0);
         chk("idle_active", int'(note_active), 0);
      end

      // Steady-state vectors: check at R+2+k, i.e. the contribution of cycle R+k.
      vt[0]  = '{8'h00, 4, 5, 0};
      vt[1]  = '{8'h01, 4, 0, -A};
      vt[2]  = '{8'h01, 4, 3, -A};
      vt[3]  = '{8'h01, 4, 4, A};
      vt[4]  = '{8'h01, 4, 8, -A};
      vt[5]  = '{8'hFF, 10, 0, -8*A};
      vt[6]  = '{8'hFF, 10, 10, 8*A};
      vt[7]  = '{8'hFF, 10, 25, -8*A};
      vt[8]  = '{8'h81, 7, 13, 2*A};
      vt[9]  = '{8'h0F, 0, 9, -4*A};
      vt[10] = '{8'h05, 1, 0, -2*A};
      vt[11] = '{8'h05, 1, 1, 2*A};
      for (int e = 0; e < 12; e++) begin
         apply_reset();
         set_hdc_all(vt[e].hdc);
         sensor = vt[e].mask;
         run_to(R + 2 + vt[e].k);
         chk($sformatf("vec%0d_sample", e), smp(), vt[e].exp_s);
         chk($sformatf("vec%0d_active", e), int'(note_active), int'(vt[e].mask));
      end

      // Gate latency for a held sensor.
      apply_reset();
      set_hdc_all(0);
      sensor = 8'h01;
      run_to(R - 1);
      chk("held_before", int'(note_active), 0);
      step();
      chk("held_on", int'(note_active), 1);

      // Short glitch: filtered with debounce, passed through one-for-one without.
      apply_reset();
      sensor = 8'h01;
`ifdef HARP_DEBOUNCE_EN
      repeat (3) step();
      sensor = 8'h00;
      repeat (15) begin
         step();
         chk("glitch_filtered", int'(note_active), 0);
      end
`else
      step();
      sensor = 8'h00;
      run_to(3);
      chk("glitch_pass", int'(note_active), 1);
      step();
      chk("glitch_end", int'(note_active), 0);
`endif

      // Mid-note pitch drop from 100 to 20 with cnt at 60.
      apply_reset();
      set_hdc_all(0);
      hdc_v[0] = 20'd100;
      sensor = 8'h01;
      run_to(R + 60);
      hdc_v[0] = 20'd20;
      run_to(R + 62);  chk("pitch_pre", smp(), -A);
      run_to(R + 63);  chk("pitch_wrap", smp(), A);
      run_to(R + 82);  chk("pitch_hi", smp(), A);
      run_to(R + 83);  chk("pitch_fall", smp(), -A);
      run_to(R + 103); chk("pitch_rise", smp(), A);

      // Backpressure holds the sample, release loads the fresh mix, reset silences at once.
      apply_reset();
      set_hdc_all(0);
      hdc_v[0] = 20'd4;
      sensor = 8'h01;
      run_to(R + 11);
      chk("bp_first", smp(), -A);
      out_ready = 1'b0;
      repeat (50) begin
         step();
         chk("bp_hold", smp(), -A);
         chk("bp_valid", int'(out_valid), 1);
      end
      out_ready = 1'b1;
      step();
      chk("bp_release", smp(), A);
      run_to(R + 70);
      reset = 1'b1;
      step();
      chk("midrst_sample", smp(), 0);
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_active", int'(note_active), 0);
      reset = 1'b0;

      run_random(1000);
      run_random(1000);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
